// File: rtl/cmn_pwm_mon_if.sv
// rtl/cmn_pwm_mon_if.sv - gate inputs, period marker and measurement/fault outputs of cmn_pwm_mon
interface cmn_pwm_mon_if;
    logic [7:0]  pwm_in;
    logic        period_start;
    logic        clear_faults;
    logic [39:0] duty_meas;
    logic [15:0] period_meas;
    logic        meas_valid;
    logic [3:0]  shoot_thru;
    logic [3:0]  deadband_err;
    logic        period_timeout;

    modport master (
        output pwm_in, period_start, clear_faults,
        input  duty_meas, period_meas, meas_valid, shoot_thru, deadband_err, period_timeout
    );

    modport slave (
        input  pwm_in, period_start, clear_faults,
        output duty_meas, period_meas, meas_valid, shoot_thru, deadband_err, period_timeout
    );
endinterface

// File: rtl/cmn_pwm_mon.sv
// rtl/cmn_pwm_mon.sv - PWM gate monitor: on-time/period measurement, shoot-through, deadband and timeout flags (option CMN_PWM_MON_SYNC_EN)
module cmn_pwm_mon #(
    parameter int          DEADBAND_TIME = 5,
    parameter logic [15:0] MAX_PERIOD    = 16'd50000,
    parameter int          PRESCALE      = 1
) (
    input  logic          clk,
    input  logic          reset,
    cmn_pwm_mon_if.slave  bus
);
    localparam int DBW = $clog2(DEADBAND_TIME + 1);
    localparam logic [DBW-1:0] DB_LOAD  = DBW'(DEADBAND_TIME);
    localparam logic [7:0]     PRE_LAST = 8'(PRESCALE - 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    logic [7:0] pwm;
    logic       ps;

`ifdef CMN_PWM_MON_SYNC_EN
    logic [7:0] pwm_s1, pwm_s2;
    logic [1:0] ps_dly;
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_s1 <= '0;
            pwm_s2 <= '0;
            ps_dly <= '0;
        end else begin
            pwm_s1 <= bus.pwm_in;
            pwm_s2 <= pwm_s1;
            ps_dly <= {ps_dly[0], bus.period_start};
        end
    end
    assign pwm = pwm_s2;
    assign ps  = ps_dly[1];
`else
    assign pwm = bus.pwm_in;
    assign ps  = bus.period_start;
`endif

    state_t           state, state_nx;
    logic [15:0]      period_cnt;
    logic [9:0]       on_cnt [4];
    logic [7:0]       presc, presc_eff, presc_nx;
    logic             tick, latch_meas, timeout_evt, counting;
    logic [7:0]       pwm_prev;
    logic [DBW-1:0]   db_h [4], db_l [4], db_h_cur [4], db_l_cur [4];
    logic [3:0]       st_evt, db_evt;
    logic [39:0]      duty_r;
    logic [15:0]      period_r;
    logic             valid_r, timeout_r;
    logic [3:0]       shoot_r, dberr_r;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ps) state_nx = MEASURE;
            MEASURE: if (!ps && period_cnt >= MAX_PERIOD) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        latch_meas  = (state == MEASURE) && ps;
        timeout_evt = (state == MEASURE) && !ps && (period_cnt >= MAX_PERIOD);
        counting    = (state == MEASURE) && !timeout_evt;
    end

    // The marker cycle itself is the first cycle of the new period, so the
    // prescaler phase is forced to 0 for it.
    always_comb begin
        presc_eff = ps ? 8'd0 : presc;
        tick      = (presc_eff == PRE_LAST);
        presc_nx  = tick ? 8'd0 : presc_eff + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
            presc      <= '0;
            for (int k = 0; k < 4; k++) on_cnt[k] <= '0;
        end else if (ps) begin
            period_cnt <= 16'd1;
            presc      <= presc_nx;
            for (int k = 0; k < 4; k++) on_cnt[k] <= {9'd0, tick & pwm[2*k]};
        end else if (counting) begin
            if (period_cnt != 16'hFFFF) period_cnt <= period_cnt + 16'd1;
            presc <= presc_nx;
            for (int k = 0; k < 4; k++)
                if (tick && pwm[2*k] && on_cnt[k] != 10'h3FF) on_cnt[k] <= on_cnt[k] + 10'd1;
        end else begin
            period_cnt <= '0;
            presc      <= '0;
            for (int k = 0; k < 4; k++) on_cnt[k] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_r   <= '0;
            period_r <= '0;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= latch_meas;
            if (latch_meas) begin
                duty_r   <= {on_cnt[3], on_cnt[2], on_cnt[1], on_cnt[0]};
                period_r <= period_cnt;
            end
        end
    end

    // A falling leg loads its guard counter in the same cycle, so a complementary
    // rise coinciding with the fall already sees a nonzero guard.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            db_h_cur[k] = (pwm_prev[2*k]   && !pwm[2*k])   ? DB_LOAD : db_h[k];
            db_l_cur[k] = (pwm_prev[2*k+1] && !pwm[2*k+1]) ? DB_LOAD : db_l[k];
            st_evt[k]   = pwm[2*k] && pwm[2*k+1];
            db_evt[k]   = (!pwm_prev[2*k+1] && pwm[2*k+1] && db_h_cur[k] != '0) ||
                          (!pwm_prev[2*k]   && pwm[2*k]   && db_l_cur[k] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_prev  <= '0;
            shoot_r   <= '0;
            dberr_r   <= '0;
            timeout_r <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                db_h[k] <= '0;
                db_l[k] <= '0;
            end
        end else begin
            pwm_prev  <= pwm;
            shoot_r   <= (bus.clear_faults ? 4'd0 : shoot_r) | st_evt;
            dberr_r   <= (bus.clear_faults ? 4'd0 : dberr_r) | db_evt;
            timeout_r <= (bus.clear_faults ? 1'b0 : timeout_r) | timeout_evt;
            for (int k = 0; k < 4; k++) begin
                db_h[k] <= (db_h_cur[k] != '0) ? db_h_cur[k] - DBW'(1) : '0;
                db_l[k] <= (db_l_cur[k] != '0) ? db_l_cur[k] - DBW'(1) : '0;
            end
        end
    end

    assign bus.duty_meas      = duty_r;
    assign bus.period_meas    = period_r;
    assign bus.meas_valid     = valid_r;
    assign bus.shoot_thru     = shoot_r;
    assign bus.deadband_err   = dberr_r;
    assign bus.period_timeout = timeout_r;
endmodule

// File: tb/tb_cmn_pwm_mon.sv
// tb/tb_cmn_pwm_mon.sv - directed table-driven bench for cmn_pwm_mon
module tb_cmn_pwm_mon;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cmn_pwm_mon_if mon_if ();

    cmn_pwm_mon #(.DEADBAND_TIME(5), .MAX_PERIOD(16'd2000), .PRESCALE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mon_if)
    );

    typedef struct {
        int          len;
        int          h0, h1, h2, h3;
        logic [39:0] exp_duty;
        logic [15:0] exp_period;
    } vec_t;

    vec_t vt [5];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [7:0] p, input int n);
        mon_if.pwm_in = p;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_ps(input logic [7:0] p);
        mon_if.pwm_in       = p;
        mon_if.period_start = 1'b1;
        step();
        mon_if.period_start = 1'b0;
    endtask

    task automatic pulse_clear(input logic [7:0] p);
        mon_if.pwm_in       = p;
        mon_if.clear_faults = 1'b1;
        step();
        mon_if.clear_faults = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_duty"},  mon_if.duty_meas, 0);
        chk({tag, "_per"},   mon_if.period_meas, 0);
        chk({tag, "_mv"},    mon_if.meas_valid, 0);
        chk({tag, "_st"},    mon_if.shoot_thru, 0);
        chk({tag, "_db"},    mon_if.deadband_err, 0);
        chk({tag, "_to"},    mon_if.period_timeout, 0);
    endtask

    // Each pair: 5 idle, high for h cycles, 5 idle, low until 5 before the end.
    function automatic logic [7:0] pat(input vec_t v, input int i);
        int h [4];
        logic [7:0] p;
        h = '{v.h0, v.h1, v.h2, v.h3};
        p = '0;
        for (int k = 0; k < 4; k++) begin
            if (i >= 5 && i < 5 + h[k])             p[2*k]   = 1'b1;
            if (i >= 10 + h[k] && i < v.len - 5)    p[2*k+1] = 1'b1;
        end
        return p;
    endfunction

    initial begin
        vt[0] = '{len:1000, h0:256,  h1:0,    h2:0,    h3:0,   exp_duty:{10'd0,   10'd0,    10'd0,    10'd256},  exp_period:16'd1000};
        vt[1] = '{len:2000, h0:0,    h1:0,    h2:2000, h3:0,   exp_duty:{10'd0,   10'd1023, 10'd0,    10'd0},    exp_period:16'd2000};
        vt[2] = '{len:600,  h0:100,  h1:200,  h2:300,  h3:400, exp_duty:{10'd400, 10'd300,  10'd200,  10'd100},  exp_period:16'd600};
        vt[3] = '{len:1500, h0:1023, h1:1024, h2:0,    h3:50,  exp_duty:{10'd50,  10'd0,    10'd1023, 10'd1023}, exp_period:16'd1500};
        vt[4] = '{len:64,   h0:1,    h1:0,    h2:54,   h3:10,  exp_duty:{10'd10,  10'd54,   10'd0,    10'd1},    exp_period:16'd64};

        reset               = 1'b1;
        mon_if.pwm_in       = '0;
        mon_if.period_start = 1'b0;
        mon_if.clear_faults = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_all_zero("reset");
        hold(8'h00, 3);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vt[v].len; i++) begin
                mon_if.pwm_in       = pat(vt[v], i);
                mon_if.period_start = (i == 0);
                step();
                if (i == 0 && v == 0) chk("mv_first_marker", mon_if.meas_valid, 0);
                if (i == 0 && v > 0) begin
                    chk("tbl_mv",     mon_if.meas_valid, 1);
                    chk("tbl_duty",   mon_if.duty_meas, vt[v-1].exp_duty);
                    chk("tbl_period", mon_if.period_meas, vt[v-1].exp_period);
                end
                if (i == 1) chk("tbl_mv_one_cycle", mon_if.meas_valid, 0);
            end
        end
        pulse_ps(8'h00);
        chk("tbl_mv_last",     mon_if.meas_valid, 1);
        chk("tbl_duty_last",   mon_if.duty_meas, vt[4].exp_duty);
        chk("tbl_period_last", mon_if.period_meas, vt[4].exp_period);
        chk("tbl_no_st", mon_if.shoot_thru, 0);
        chk("tbl_no_db", mon_if.deadband_err, 0);
        chk("tbl_no_to", mon_if.period_timeout, 0);

        // Deadband on pair 1: gaps of 3 and 4 violate, 5 is legal.
        hold(8'h04, 3);
        hold(8'h00, 3);
        hold(8'h08, 2);
        chk("db_gap3", mon_if.deadband_err, 4'b0010);
        pulse_clear(8'h08);
        chk("db_clear", mon_if.deadband_err, 0);
        hold(8'h00, 5);
        hold(8'h04, 3);
        hold(8'h00, 5);
        hold(8'h08, 3);
        chk("db_gap5", mon_if.deadband_err, 0);
        hold(8'h00, 4);
        hold(8'h04, 2);
        chk("db_gap4", mon_if.deadband_err, 4'b0010);
        pulse_clear(8'h04);
        chk("db_clear2", mon_if.deadband_err, 0);
        hold(8'h00, 8);

        // Shoot-through on pair 1, stickiness and set-beats-clear.
        hold(8'h0C, 1);
        hold(8'h00, 3);
        chk("st_set", mon_if.shoot_thru, 4'b0010);
        hold(8'h00, 10);
        chk("st_sticky", mon_if.shoot_thru, 4'b0010);
        pulse_clear(8'h00);
        chk("st_clear", mon_if.shoot_thru, 0);
        hold(8'h00, 3);
        pulse_clear(8'h0C);
        mon_if.pwm_in = 8'h00;
        chk("st_clr_vs_set", mon_if.shoot_thru, 4'b0010);
        chk("st_no_db", mon_if.deadband_err, 0);
        hold(8'h00, 8);

        // Timeout exactly MAX_PERIOD cycles after the last marker.
        pulse_ps(8'h00);
        hold(8'h00, 1999);
        chk("to_before", mon_if.period_timeout, 0);
        hold(8'h00, 1);
        chk("to_set", mon_if.period_timeout, 1);
        hold(8'h00, 5);
        pulse_ps(8'h00);
        chk("to_idle_no_mv", mon_if.meas_valid, 0);
        chk("to_kept", mon_if.period_timeout, 1);
        hold(8'h00, 10);
        hold(8'h01, 100);
        hold(8'h00, 189);
        pulse_ps(8'h00);
        chk("resume_mv",     mon_if.meas_valid, 1);
        chk("resume_period", mon_if.period_meas, 300);
        chk("resume_duty",   mon_if.duty_meas, 40'd100);

        // Reset mid-period discards everything.
        hold(8'h01, 50);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("midrst");
        hold(8'h01, 20);
        pulse_ps(8'h01);
        chk("midrst_ps1_mv", mon_if.meas_valid, 0);
        hold(8'h01, 49);
        hold(8'h00, 50);
        pulse_ps(8'h00);
        chk("midrst_ps2_mv",     mon_if.meas_valid, 1);
        chk("midrst_ps2_period", mon_if.period_meas, 100);
        chk("midrst_ps2_duty",   mon_if.duty_meas, 40'd50);
        hold(8'h00, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
